blob_bbox_accumulator: RTL

Frame-level feature extractor downstream of the sensor's stream counter. It consumes the eroded, coordinate-tagged 3-bit pixel stream (red/green/blue masks). For each colour channel it accumulates the bounding box and pixel count of set pixels over one frame. On end-of-frame it latches the results into a read-only register bank read by the processor. This bank gives the raw robot/obstacle extents used for position calculation.

---
 rtl/blob_bbox_accumulator_if.sv | 35 +++
 rtl/blob_bbox_accumulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/blob_bbox_accumulator_if.sv
// Bus bundle for blob_bbox_accumulator: the pixel stream, frame control,
// register read port and status.
//
// Handshake: in_write qualifies in_pixel/in_x/in_y in the cycle it is high.
// The sink never applies back-pressure, so every qualified pixel is taken
// at the clock edge that samples it. The register port is a plain
// registered read: address sampled at edge k gives readdata after edge k.
// out_valid is a single-cycle pulse marking the edge at which a new set of
// frame results, and ready=1, become visible.
interface blob_bbox_accumulator_if #(
  parameter int COORD_W = 12
);
  logic               start;
  logic               in_write;
  logic [2:0]         in_pixel;
  logic [COORD_W-1:0] in_x;
  logic [COORD_W-1:0] in_y;
  logic               in_done;
  logic [3:0]         address;
  logic [31:0]        readdata;
  logic               busy;
  logic               ready;
  logic               out_valid;
  logic [1:0]         state_dbg;

  modport master (
    output start, in_write, in_pixel, in_x, in_y, in_done, address,
    input  readdata, busy, ready, out_valid, state_dbg
  );

  modport slave (
    input  start, in_write, in_pixel, in_x, in_y, in_done, address,
    output readdata, busy, ready, out_valid, state_dbg
  );
endinterface

// File: rtl/blob_bbox_accumulator.sv
// Per-channel (red/green/blue) bounding box and pixel count over one frame
// of a coordinate-tagged mask stream. Results are latched on the rising
// edge of in_done into a read-only register bank.
module blob_bbox_accumulator #(
  parameter int COORD_W = 12,
  parameter int COUNT_W = 24
) (
  input  logic                          clock,
  input  logic                          reset_n,
  blob_bbox_accumulator_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ACCUM = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic done_q;
  logic done_rise;
  logic origin;
  logic acc_clr;
  logic acc_en;
  logic [2:0] hit;

  logic [COORD_W-1:0] acc_min_x [3];
  logic [COORD_W-1:0] acc_min_y [3];
  logic [COORD_W-1:0] acc_max_x [3];
  logic [COORD_W-1:0] acc_max_y [3];
  logic [COUNT_W-1:0] acc_cnt   [3];

  logic [COORD_W-1:0] res_min_x [3];
  logic [COORD_W-1:0] res_min_y [3];
  logic [COORD_W-1:0] res_max_x [3];
  logic [COORD_W-1:0] res_max_y [3];
  logic [COUNT_W-1:0] res_cnt   [3];

  logic        busy_q;
  logic        ready_q;
  logic        out_valid_q;
  logic [31:0] rd_q;
  logic [31:0] rd_next;

  logic [COORD_W-1:0] sel_min_x;
  logic [COORD_W-1:0] sel_min_y;
  logic [COORD_W-1:0] sel_max_x;
  logic [COORD_W-1:0] sel_max_y;
  logic [COUNT_W-1:0] sel_cnt;
  logic               sel_ok;

  // Channel 0 is red (in_pixel[2]), channel 2 is blue (in_pixel[0]).
  assign hit       = {bus.in_pixel[0], bus.in_pixel[1], bus.in_pixel[2]};
  assign done_rise = bus.in_done & ~done_q;
  assign origin    = (bus.in_x == '0) && (bus.in_y == '0);
  assign acc_clr   = (state == S_IDLE) && bus.start;
  // The (0,0) pixel that ends WAIT belongs to the new frame.
  assign acc_en    = bus.in_write &&
                     (((state == S_WAIT) && origin) || (state == S_ACCUM));

  assign bus.busy      = busy_q;
  assign bus.ready     = ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.readdata  = rd_q;
  assign bus.state_dbg = state;

  // State register and in_done edge history; the history resets to 1 so a
  // level that is already high cannot close a frame after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      done_q <= 1'b1;
    end else begin
      state  <= state_next;
      done_q <= bus.in_done;
    end
  end

  // Next-state logic; in_done edges seen in WAIT belong to a stale frame.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = S_WAIT;
      S_WAIT:  if (bus.in_write && origin) state_next = S_ACCUM;
      S_ACCUM: if (done_rise) state_next = S_LATCH;
      S_LATCH: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Accumulators: cleared on arm, updated per set mask bit, count saturates.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 3; c++) begin
        acc_min_x[c] <= '0;
        acc_min_y[c] <= '0;
        acc_max_x[c] <= '0;
        acc_max_y[c] <= '0;
        acc_cnt[c]   <= '0;
      end
    end else if (acc_clr) begin
      for (int c = 0; c < 3; c++) begin
        acc_min_x[c] <= '1;
        acc_min_y[c] <= '1;
        acc_max_x[c] <= '0;
        acc_max_y[c] <= '0;
        acc_cnt[c]   <= '0;
      end
    end else if (acc_en) begin
      for (int c = 0; c < 3; c++) begin
        if (hit[c]) begin
          if (bus.in_x < acc_min_x[c]) acc_min_x[c] <= bus.in_x;
          if (bus.in_y < acc_min_y[c]) acc_min_y[c] <= bus.in_y;
          if (bus.in_x > acc_max_x[c]) acc_max_x[c] <= bus.in_x;
          if (bus.in_y > acc_max_y[c]) acc_max_y[c] <= bus.in_y;
          if (acc_cnt[c] != {COUNT_W{1'b1}}) acc_cnt[c] <= acc_cnt[c] + COUNT_W'(1);
        end
      end
    end
  end

  // Result bank: snapshot of the accumulators taken in LATCH.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 3; c++) begin
        res_min_x[c] <= '0;
        res_min_y[c] <= '0;
        res_max_x[c] <= '0;
        res_max_y[c] <= '0;
        res_cnt[c]   <= '0;
      end
    end else if (state == S_LATCH) begin
      for (int c = 0; c < 3; c++) begin
        res_min_x[c] <= acc_min_x[c];
        res_min_y[c] <= acc_min_y[c];
        res_max_x[c] <= acc_max_x[c];
        res_max_y[c] <= acc_max_y[c];
        res_cnt[c]   <= acc_cnt[c];
      end
    end
  end

  // Status flags: busy follows the armed states, ready/out_valid mark a latch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      busy_q      <= (state_next != S_IDLE);
      out_valid_q <= (state == S_LATCH);
      if (state == S_LATCH) ready_q <= 1'b1;
      else if (acc_clr)     ready_q <= 1'b0;
    end
  end

  // Read mux: address[3:2] picks the channel, address[1:0] the field.
  always_comb begin
    sel_min_x = '0;
    sel_min_y = '0;
    sel_max_x = '0;
    sel_max_y = '0;
    sel_cnt   = '0;
    sel_ok    = 1'b1;
    case (bus.address[3:2])
      2'd0: begin
        sel_min_x = res_min_x[0]; sel_min_y = res_min_y[0];
        sel_max_x = res_max_x[0]; sel_max_y = res_max_y[0];
        sel_cnt   = res_cnt[0];
      end
      2'd1: begin
        sel_min_x = res_min_x[1]; sel_min_y = res_min_y[1];
        sel_max_x = res_max_x[1]; sel_max_y = res_max_y[1];
        sel_cnt   = res_cnt[1];
      end
      2'd2: begin
        sel_min_x = res_min_x[2]; sel_min_y = res_min_y[2];
        sel_max_x = res_max_x[2]; sel_max_y = res_max_y[2];
        sel_cnt   = res_cnt[2];
      end
      default: sel_ok = 1'b0;
    endcase
    rd_next = '0;
    if (sel_ok) begin
      case (bus.address[1:0])
        2'd0:    rd_next = {16'(sel_min_y), 16'(sel_min_x)};
        2'd1:    rd_next = {16'(sel_max_y), 16'(sel_max_x)};
        2'd2:    rd_next = 32'(sel_cnt);
        default: rd_next = '0;
      endcase
    end else if (bus.address == 4'd12) begin
      rd_next = {30'b0, busy_q, ready_q};
    end
  end

  // Registered read data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rd_q <= '0;
    else          rd_q <= rd_next;
  end

endmodule
